// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: paces the N-deep delay line, selects
// butterfly vs. fill, addresses the twiddle ROM and drains the line after the last sample.
module sdf_stage_ctrl #(
    parameter int N     = 64,
    parameter int LOG2N = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             sr_shift,
    output logic             flush,
    output logic             bf_sel,
    output logic             tw_en,
    output logic [LOG2N-1:0] tw_addr,
    output logic             out_valid,
    output logic             out_sof,
    output logic             busy,
    output logic             err_align
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [LOG2N:0] CNT_ONE  = (LOG2N+1)'(1);
    localparam logic [LOG2N:0] CNT_PRE  = (LOG2N+1)'(N - 1);
    localparam logic [LOG2N:0] CNT_HALF = (LOG2N+1)'(N);
    localparam logic [LOG2N:0] CNT_LAST = (LOG2N+1)'(2 * N - 1);

    state_t           state_q, state_d;
    logic [LOG2N:0]   cnt_q, cnt_d;
    logic [LOG2N:0]   fcnt_q, fcnt_d;
    logic             primed_q, primed_d;
    logic             err_align_q, err_align_d;

    logic             acc;
    logic             tick;
    logic             flush_done;

    // A sample offered during the flush is not accepted and leaves no trace.
    assign acc        = in_valid & (state_q != FLUSH);
    assign tick       = acc | (state_q == FLUSH);
    assign flush_done = (state_q == FLUSH) & (fcnt_q == CNT_ONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fcnt_q      <= '0;
            primed_q    <= 1'b0;
            err_align_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fcnt_q      <= fcnt_d;
            primed_q    <= primed_d;
            err_align_q <= err_align_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fcnt_d      = fcnt_q;
        primed_d    = primed_q;
        err_align_d = err_align_q;

        // cnt spans exactly 2N values, so the increment wraps 2N-1 -> 0 on its own.
        if (tick) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_PRE) begin
                primed_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE, RUN: begin
                if (acc) begin
                    if (in_last) begin
                        state_d = FLUSH;
                        fcnt_d  = CNT_HALF;
                        if (cnt_q != CNT_LAST) begin
                            err_align_d = 1'b1;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
                fcnt_d = fcnt_q - CNT_ONE;
                if (flush_done) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    primed_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output qualifies the sample presented in the same cycle.
    always_comb begin
        in_ready  = (state_q != FLUSH);
        busy      = (state_q != IDLE);
        flush     = (state_q == FLUSH);
        sr_shift  = tick;
        bf_sel    = cnt_q[LOG2N];
        tw_en     = tick & primed_q & ~cnt_q[LOG2N];
        tw_addr   = cnt_q[LOG2N-1:0];
        out_valid = tick & primed_q;
        out_sof   = tick & primed_q & (cnt_q == CNT_HALF);
        err_align = err_align_q;
    end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed bench for sdf_stage_ctrl at N=4: reset, single/gapped/back-to-back frames,
// misaligned last and reset during the flush.
module tb_sdf_stage_ctrl;

    localparam int N     = 4;
    localparam int LOG2N = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready, sr_shift, flush, bf_sel, tw_en;
    logic [LOG2N-1:0] tw_addr;
    logic             out_valid, out_sof, busy, err_align;

    int errors = 0;
    int checks = 0;

    // {in_ready, sr_shift, flush, bf_sel, tw_en, out_valid, out_sof}
    wire [6:0] flags = {in_ready, sr_shift, flush, bf_sel, tw_en, out_valid, out_sof};

    sdf_stage_ctrl #(.N(N), .LOG2N(LOG2N)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .sr_shift(sr_shift), .flush(flush), .bf_sel(bf_sel),
        .tw_en(tw_en), .tw_addr(tw_addr), .out_valid(out_valid), .out_sof(out_sof),
        .busy(busy), .err_align(err_align)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic l);
        @(negedge clk);
        in_valid = v;
        in_last  = l;
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) drive(1'b0, 1'b0);
        checks++;
        if (flags !== 7'b1000000) begin
            errors++; $display("FAIL reset_flags: got %b want %b", flags, 7'b1000000);
        end
        checks++;
        if (busy !== 1'b0 || err_align !== 1'b0) begin
            errors++; $display("FAIL reset_busy_err: got busy=%b err=%b want 0 0", busy, err_align);
        end
        checks++;
        if (tw_addr !== 2'd0) begin
            errors++; $display("FAIL reset_tw_addr: got %0d want 0", tw_addr);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_one_frame;
        int nout = 0;
        logic [6:0] exp;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 7);
            exp = {1'b1, 1'b1, 1'b0, i >= 4, 1'b0, i >= 4, i == 4};
            nout += int'(out_valid);
            checks++;
            if (flags !== exp || tw_addr !== 2'(i)) begin
                errors++; $display("FAIL frame_sample[%0d]: got flags=%b addr=%0d want %b %0d", i, flags, tw_addr, exp, 2'(i));
            end
            checks++;
            if (busy !== (i != 0)) begin
                errors++; $display("FAIL frame_busy[%0d]: got %b want %b", i, busy, i != 0);
            end
        end
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 1'b0);
            nout += int'(out_valid);
            checks++;
            if (flags !== 7'b0110110 || tw_addr !== 2'(j) || busy !== 1'b1) begin
                errors++; $display("FAIL frame_flush[%0d]: got flags=%b addr=%0d busy=%b want 0110110 %0d 1", j, flags, tw_addr, busy, j);
            end
        end
        drive(1'b0, 1'b0);
        checks++;
        if (flags !== 7'b1000000 || busy !== 1'b0) begin
            errors++; $display("FAIL frame_idle: got flags=%b busy=%b want 1000000 0", flags, busy);
        end
        checks++;
        if (nout !== 8) begin
            errors++; $display("FAIL frame_count: got %0d want 8", nout);
        end
    endtask

    task automatic test_gapped;
        int nout = 0;
        int s;
        logic [6:0] exp;
        logic [1:0] ea;
        for (int c = 0; c < 15; c++) begin
            s = c / 2;
            drive((c % 2) == 0, c == 14);
            if ((c % 2) == 0) begin
                exp = {1'b1, 1'b1, 1'b0, s >= 4, 1'b0, s >= 4, s == 4};
                ea  = 2'(s);
            end else begin
                exp = {1'b1, 1'b0, 1'b0, (s + 1) >= 4, 1'b0, 1'b0, 1'b0};
                ea  = 2'(s + 1);
            end
            nout += int'(out_valid);
            checks++;
            if (flags !== exp || tw_addr !== ea) begin
                errors++; $display("FAIL gap_cycle[%0d]: got flags=%b addr=%0d want %b %0d", c, flags, tw_addr, exp, ea);
            end
        end
        // Offered samples during the flush must be dropped.
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 1'b1);
            nout += int'(out_valid);
            checks++;
            if (flags !== 7'b0110110 || tw_addr !== 2'(j)) begin
                errors++; $display("FAIL gap_flush[%0d]: got flags=%b addr=%0d want 0110110 %0d", j, flags, tw_addr, j);
            end
        end
        drive(1'b0, 1'b0);
        checks++;
        if (flags !== 7'b1000000 || busy !== 1'b0 || nout !== 8) begin
            errors++; $display("FAIL gap_end: got flags=%b busy=%b outs=%0d want 1000000 0 8", flags, busy, nout);
        end
    endtask

    task automatic test_back_to_back;
        int nout = 0;
        logic bf;
        logic [6:0] exp;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i == 15);
            bf  = (i % 8) >= 4;
            exp = {1'b1, 1'b1, 1'b0, bf, (i >= 8) && !bf, i >= 4, (i == 4) || (i == 12)};
            nout += int'(out_valid);
            checks++;
            if (flags !== exp || tw_addr !== 2'(i)) begin
                errors++; $display("FAIL b2b_sample[%0d]: got flags=%b addr=%0d want %b %0d", i, flags, tw_addr, exp, 2'(i));
            end
        end
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 1'b0);
            nout += int'(out_valid);
        end
        checks++;
        if (nout !== 16) begin
            errors++; $display("FAIL b2b_count: got %0d want 16", nout);
        end
        drive(1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0 || err_align !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got busy=%b err=%b want 0 0", busy, err_align);
        end
    endtask

    task automatic test_misaligned;
        logic bf;
        logic [6:0] exp;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, i == 5);
            exp = {1'b1, 1'b1, 1'b0, i >= 4, 1'b0, i >= 4, i == 4};
            checks++;
            if (flags !== exp) begin
                errors++; $display("FAIL mis_sample[%0d]: got %b want %b", i, flags, exp);
            end
        end
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 1'b0);
            bf  = j < 2;
            exp = {1'b0, 1'b1, 1'b1, bf, !bf, 1'b1, 1'b0};
            checks++;
            if (flags !== exp || tw_addr !== 2'(6 + j) || err_align !== 1'b1) begin
                errors++; $display("FAIL mis_flush[%0d]: got flags=%b addr=%0d err=%b want %b %0d 1", j, flags, tw_addr, err_align, exp, 2'(6 + j));
            end
        end
        drive(1'b0, 1'b0);
        checks++;
        if (flags !== 7'b1000000 || busy !== 1'b0 || err_align !== 1'b1 || tw_addr !== 2'd0) begin
            errors++; $display("FAIL mis_idle: got flags=%b busy=%b err=%b addr=%0d want 1000000 0 1 0", flags, busy, err_align, tw_addr);
        end
    endtask

    task automatic test_reset_mid_flush;
        logic [6:0] exp;
        for (int i = 0; i < 8; i++) drive(1'b1, i == 7);
        drive(1'b0, 1'b0);
        checks++;
        if (flags !== 7'b0110110) begin
            errors++; $display("FAIL rmf_flush1: got %b want 0110110", flags);
        end
        drive(1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        checks++;
        if (flags !== 7'b0110110) begin
            errors++; $display("FAIL rmf_flush2: got %b want 0110110", flags);
        end
        drive(1'b0, 1'b0);
        reset_n = 1'b1;
        #1;
        checks++;
        if (flags !== 7'b1000000 || busy !== 1'b0 || err_align !== 1'b0 || tw_addr !== 2'd0) begin
            errors++; $display("FAIL rmf_after: got flags=%b busy=%b err=%b addr=%0d want 1000000 0 0 0", flags, busy, err_align, tw_addr);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 7);
            exp = {1'b1, 1'b1, 1'b0, i >= 4, 1'b0, i >= 4, i == 4};
            checks++;
            if (flags !== exp || tw_addr !== 2'(i)) begin
                errors++; $display("FAIL rmf_new[%0d]: got flags=%b addr=%0d want %b %0d", i, flags, tw_addr, exp, 2'(i));
            end
        end
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 1'b0);
            checks++;
            if (flags !== 7'b0110110 || tw_addr !== 2'(j)) begin
                errors++; $display("FAIL rmf_newflush[%0d]: got flags=%b addr=%0d want 0110110 %0d", j, flags, tw_addr, j);
            end
        end
        drive(1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0 || flags !== 7'b1000000) begin
            errors++; $display("FAIL rmf_end: got flags=%b busy=%b want 1000000 0", flags, busy);
        end
    endtask

    initial begin
        test_reset();
        test_one_frame();
        test_gapped();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
